sha256_engine_param: RTL and testbench

//  Parametrised SHA-256 compression engine; successor to the fixed 1-round/2-cycle core.

---
 rtl/sha256_engine_param.sv | 244 ++++++++++++++++++++++++
 tb/tb_sha256_engine_param.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_engine_param.sv
// SHA-256 compression engine with RPC rounds per clock, first/last block chaining,
// optional midstate preload and optional in-engine second pass (SHA256d).
module sha256_engine_param #(
  parameter int RPC     = 1,
  parameter bit DOUBLE  = 1'b1,
  parameter bit IV_LOAD = 1'b1
) (
  input  logic         CLK,
  input  logic         nreset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] msg,
  input  logic         first,
  input  logic         last,
  input  logic         dbl,
  input  logic         iv_sel,
  input  logic [255:0] iv_in,
  output logic [255:0] hash,
  output logic         hash_valid,
  output logic         blk_done,
  output logic         busy
);

  localparam logic [255:0] STD_IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [6:0] RPC_STEP = 7'(RPC);
  localparam logic [6:0] LAST_RND = 7'(64 - RPC);

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DBL   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  state_t       state_r;
  logic [255:0] h_r;
  logic [31:0]  wv_r [8];
  logic [31:0]  w_r [16];
  logic [6:0]   round_r;
  logic [511:0] msg_r;
  logic [255:0] iv_r;
  logic         first_r;
  logic         last_r;
  logic         iv_sel_r;
  logic         dbl_r;
  logic         chain_r;

  logic         accept_s;
  logic [31:0]  ext_s [16+RPC];
  logic [31:0]  v_s [8];
  logic [31:0]  wn_s [16];
  logic [31:0]  t1_s;
  logic [31:0]  t2_s;
  logic [255:0] h_init_s;
  logic [255:0] h_sum_s;

  assign accept_s = in_valid & in_ready & (state_r == S_IDLE);

  // Chaining value at INIT: IV or midstate for a first block, running H otherwise
  always_comb begin
    h_init_s = h_r;
    if (first_r) begin
      if (IV_LOAD && iv_sel_r) begin
        h_init_s = iv_r;
      end else begin
        h_init_s = STD_IV;
      end
    end else begin
      h_init_s = h_r;
    end
  end

  // RPC chained rounds; the window extends by RPC scheduled words then slides by RPC
  always_comb begin
    t1_s = 32'h0;
    t2_s = 32'h0;
    for (int k = 0; k < 16; k++) ext_s[k] = w_r[k];
    for (int j = 0; j < RPC; j++) begin
      ext_s[16+j] = ssig1(ext_s[14+j]) + ext_s[9+j] + ssig0(ext_s[1+j]) + ext_s[j];
    end
    for (int k = 0; k < 8; k++) v_s[k] = wv_r[k];
    for (int i = 0; i < RPC; i++) begin
      t1_s = v_s[7] + bsig1(v_s[4]) + ch(v_s[4], v_s[5], v_s[6])
           + K_TAB[round_r[5:0] + 6'(i)] + ext_s[i];
      t2_s = bsig0(v_s[0]) + maj(v_s[0], v_s[1], v_s[2]);
      v_s[7] = v_s[6];
      v_s[6] = v_s[5];
      v_s[5] = v_s[4];
      v_s[4] = v_s[3] + t1_s;
      v_s[3] = v_s[2];
      v_s[2] = v_s[1];
      v_s[1] = v_s[0];
      v_s[0] = t1_s + t2_s;
    end
    for (int k = 0; k < 16; k++) wn_s[k] = ext_s[k+RPC];
  end

  // Per-word feed-forward of the working variables into H
  always_comb begin
    h_sum_s = 256'h0;
    for (int k = 0; k < 8; k++) begin
      h_sum_s[255-32*k -: 32] = h_r[255-32*k -: 32] + wv_r[k];
    end
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge CLK or negedge nreset) begin
    if (!nreset) begin
      state_r    <= S_IDLE;
      h_r        <= STD_IV;
      round_r    <= 7'd0;
      msg_r      <= 512'h0;
      iv_r       <= 256'h0;
      first_r    <= 1'b0;
      last_r     <= 1'b0;
      iv_sel_r   <= 1'b0;
      dbl_r      <= 1'b0;
      chain_r    <= 1'b0;
      hash       <= 256'h0;
      hash_valid <= 1'b0;
      blk_done   <= 1'b0;
      busy       <= 1'b0;
      in_ready   <= 1'b0;
      for (int k = 0; k < 8; k++) wv_r[k] <= 32'h0;
      for (int k = 0; k < 16; k++) w_r[k] <= 32'h0;
    end else begin
      hash_valid <= 1'b0;
      blk_done   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            msg_r    <= msg;
            first_r  <= first;
            last_r   <= last;
            iv_sel_r <= iv_sel;
            iv_r     <= iv_in;
            if (first) begin
              dbl_r <= dbl & DOUBLE;
            end else begin
              dbl_r <= dbl_r;
            end
            busy     <= 1'b1;
            in_ready <= 1'b0;
            state_r  <= S_INIT;
          end else begin
            busy     <= chain_r;
            in_ready <= 1'b1;
          end
        end
        S_INIT: begin
          h_r     <= h_init_s;
          round_r <= 7'd0;
          for (int k = 0; k < 8; k++) wv_r[k] <= h_init_s[255-32*k -: 32];
          for (int k = 0; k < 16; k++) w_r[k] <= msg_r[511-32*k -: 32];
          state_r <= S_ROUND;
        end
        S_ROUND: begin
          for (int k = 0; k < 8; k++) wv_r[k] <= v_s[k];
          for (int k = 0; k < 16; k++) w_r[k] <= wn_s[k];
          round_r <= round_r + RPC_STEP;
          if (round_r == LAST_RND) begin
            state_r <= S_FINAL;
          end else begin
            state_r <= S_ROUND;
          end
        end
        S_FINAL: begin
          h_r      <= h_sum_s;
          blk_done <= 1'b1;
          if (!last_r) begin
            chain_r  <= 1'b1;
            in_ready <= 1'b1;
            state_r  <= S_IDLE;
          end else if (dbl_r) begin
            chain_r  <= 1'b0;
            dbl_r    <= 1'b0;
            state_r  <= S_DBL;
          end else begin
            chain_r  <= 1'b0;
            state_r  <= S_DONE;
          end
        end
        S_DBL: begin
          // Second pass hashes the 256-bit digest as a single padded block
          msg_r    <= {h_r, 32'h80000000, 192'h0, 32'h00000100};
          h_r      <= STD_IV;
          first_r  <= 1'b1;
          iv_sel_r <= 1'b0;
          last_r   <= 1'b1;
          state_r  <= S_INIT;
        end
        S_DONE: begin
          hash       <= h_r;
          hash_valid <= 1'b1;
          in_ready   <= 1'b1;
          state_r    <= S_IDLE;
        end
        default: begin
          in_ready <= 1'b0;
          state_r  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_engine_param.sv
// Drives four engine instances (RPC = 1, 2, 4, 8) with shared stimulus and scores digests,
// latency and blk_done counts per instance against an expectation queue.
module tb_sha256_engine_param;

  localparam int NI = 4;
  localparam logic [255:0] STD_IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_T1 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_T2 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] D_T3 = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
  localparam logic [511:0] B_ABC = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] B_T2A = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
    32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B_T2B = {480'h0, 32'h000001c0};

  localparam logic [31:0] KM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct packed {
    logic [255:0] dig;
    logic [31:0]  lat;
    logic [31:0]  nblk;
  } exp_t;

  logic            CLK = 1'b0;
  logic            nreset = 1'b0;
  logic [NI-1:0]   in_valid = '0;
  logic [511:0]    msg = '0;
  logic            first = 1'b0;
  logic            last = 1'b0;
  logic            dbl = 1'b0;
  logic            iv_sel = 1'b0;
  logic [255:0]    iv_in = '0;
  logic [NI-1:0]   ready_v;
  logic [NI-1:0]   hv_v;
  logic [NI-1:0]   bd_v;
  logic [NI-1:0]   busy_v;
  logic [255:0]    hash_a [NI];

  exp_t exp_q [NI][$];
  int   checks = 0;
  int   passed = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cyc [NI];
  int   bd_cnt [NI];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sha256_engine_param #(.RPC(1 << g), .DOUBLE(1'b1), .IV_LOAD(1'b1)) u_dut (
      .CLK(CLK), .nreset(nreset), .in_valid(in_valid[g]), .in_ready(ready_v[g]),
      .msg(msg), .first(first), .last(last), .dbl(dbl), .iv_sel(iv_sel), .iv_in(iv_in),
      .hash(hash_a[g]), .hash_valid(hv_v[g]), .blk_done(bd_v[g]), .busy(busy_v[g]));
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straightforward one-block SHA-256 compression used as the reference
  function automatic logic [255:0] sha_model(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, gg, hh, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, b, c, d, e, f, gg, hh} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & gg)) + KM[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = gg; gg = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
            e + hin[127:96], f + hin[95:64], gg + hin[63:32], hh + hin[31:0]};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_mon
    exp_t cur;
    always @(negedge CLK) begin
      if (!nreset) begin
        bd_cnt[g] = 0;
      end else begin
        if (in_valid[g] && ready_v[g] && first) acc_cyc[g] = cyc;
        if (bd_v[g]) bd_cnt[g]++;
        if (hv_v[g]) begin
          checks++;
          assert (exp_q[g].size() > 0) passed++;
          else begin
            fails++;
            $error("FAIL rpc%0d unexpected hash_valid: observed hash %h expected no pulse", 1 << g, hash_a[g]);
          end
          if (exp_q[g].size() > 0) begin
            cur = exp_q[g].pop_front();
            chk($sformatf("rpc%0d digest", 1 << g), hash_a[g], cur.dig);
            chk($sformatf("rpc%0d latency", 1 << g), 256'(cyc - acc_cyc[g] - 1), 256'(cur.lat));
            chk($sformatf("rpc%0d blk_done count", 1 << g), 256'(bd_cnt[g]), 256'(cur.nblk));
          end
          bd_cnt[g] = 0;
        end
      end
    end
  end

  task automatic expect_all(input logic [255:0] dig, input int passes, input int nblk);
    exp_t e;
    for (int g = 0; g < NI; g++) begin
      e.dig  = dig;
      e.lat  = 32'(passes * ((64 >> g) + 3));
      e.nblk = 32'(nblk);
      exp_q[g].push_back(e);
    end
  endtask

  task automatic send(input logic [511:0] b, input logic f, input logic l, input logic d,
                      input logic s, input logic [255:0] iv);
    logic [NI-1:0] acc;
    int t;
    msg = b; first = f; last = l; dbl = d; iv_sel = s; iv_in = iv;
    in_valid = '1;
    t = 0;
    while (t < 400 && in_valid != '0) begin
      @(negedge CLK);
      acc = in_valid & ready_v;
      @(posedge CLK);
      #1;
      in_valid = in_valid & ~acc;
      t++;
    end
    chk("accept timeout", 256'(in_valid), 256'(0));
    in_valid = '0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    logic pend;
    t = 0;
    pend = 1'b1;
    while (t < 400 && pend) begin
      @(posedge CLK);
      #1;
      pend = (ready_v != '1);
      for (int g = 0; g < NI; g++) if (exp_q[g].size() != 0) pend = 1'b1;
      t++;
    end
    chk({tag, " completion"}, 256'(pend), 256'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("%s rpc%0d hash", tag, 1 << g), hash_a[g], 256'h0);
      chk($sformatf("%s rpc%0d ctl", tag, 1 << g),
          256'({hv_v[g], bd_v[g], busy_v[g], ready_v[g]}), 256'(0));
    end
  endtask

  initial begin
    logic [255:0] mid;
    logic [511:0] rb;

    nreset = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    nreset = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("idle in_ready", 256'(ready_v), 256'(4'hF));
    chk("idle busy", 256'(busy_v), 256'(0));

    // T1 single block "abc"
    expect_all(D_T1, 1, 1);
    send(B_ABC, 1'b1, 1'b1, 1'b0, 1'b0, 256'h0);
    chk("busy after accept", 256'(busy_v), 256'(4'hF));
    wait_idle("t1");

    // T2 two-block chain; block 2 is held valid until each engine returns to IDLE
    expect_all(D_T2, 2, 2);
    send(B_T2A, 1'b1, 1'b0, 1'b0, 1'b0, 256'h0);
    send(B_T2B, 1'b0, 1'b1, 1'b0, 1'b0, 256'h0);
    wait_idle("t2");

    // T3 SHA256d of "abc"
    expect_all(D_T3, 2, 2);
    send(B_ABC, 1'b1, 1'b1, 1'b1, 1'b0, 256'h0);
    wait_idle("t3");

    // T4 midstate: block 1 alone, then block 2 seeded from its chaining value
    mid = sha_model(STD_IV, B_T2A);
    expect_all(mid, 1, 1);
    send(B_T2A, 1'b1, 1'b1, 1'b0, 1'b0, 256'h0);
    wait_idle("t4 mid");
    expect_all(D_T2, 1, 1);
    send(B_T2B, 1'b1, 1'b1, 1'b0, 1'b1, mid);
    wait_idle("t4");

    // Restart: an open chain is discarded by a new first block
    expect_all(D_T1, 1, 2);
    send(B_T2A, 1'b1, 1'b0, 1'b0, 1'b0, 256'h0);
    send(B_ABC, 1'b1, 1'b1, 1'b0, 1'b0, 256'h0);
    wait_idle("restart");

    // dbl on a non-first block has no effect
    expect_all(D_T2, 2, 2);
    send(B_T2A, 1'b1, 1'b0, 1'b0, 1'b0, 256'h0);
    send(B_T2B, 1'b0, 1'b1, 1'b1, 1'b0, 256'h0);
    wait_idle("late dbl");

    // Random block, single and double hash against the reference
    for (int k = 0; k < 16; k++) rb[511-32*k -: 32] = $urandom();
    expect_all(sha_model(STD_IV, rb), 1, 1);
    send(rb, 1'b1, 1'b1, 1'b0, 1'b0, 256'h0);
    wait_idle("random");
    mid = sha_model(STD_IV, rb);
    expect_all(sha_model(STD_IV, {mid, 32'h80000000, 192'h0, 32'h00000100}), 2, 2);
    send(rb, 1'b1, 1'b1, 1'b1, 1'b0, 256'h0);
    wait_idle("random dbl");

    // T6 abort at round 30 of the RPC=1 engine, then rerun
    expect_all(D_T1, 1, 1);
    send(B_ABC, 1'b1, 1'b1, 1'b0, 1'b0, 256'h0);
    repeat (31) @(posedge CLK);
    #1;
    chk("mid-run rpc1 in_ready", 256'(ready_v[0]), 256'(0));
    chk("mid-run rpc1 busy", 256'(busy_v[0]), 256'(1));
    nreset = 1'b0;
    for (int g = 0; g < NI; g++) exp_q[g].delete();
    #1;
    check_reset_outputs("abort");
    repeat (3) @(posedge CLK);
    #1;
    nreset = 1'b1;
    repeat (80) @(posedge CLK);
    #1;
    chk("post-abort idle", 256'({busy_v, hv_v}), 256'(0));
    expect_all(D_T1, 1, 1);
    send(B_ABC, 1'b1, 1'b1, 1'b0, 1'b0, 256'h0);
    wait_idle("rerun");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
